inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
Decoupled instruction-fetch front end between Instruction_Memory and the IF/ID pipeline register. It issues sequential fetch requests to instruction memory, tracks in-order responses, and buffers {PC, instruction} pairs in a small FIFO for the decode stage. A redirect from EX (branch mispredict, or a taken branch) flushes the queue and squashes in-flight responses, so fetch latency and decode stalls never corrupt the PC/instruction pairing.

Parameters:
DEPTH, 4, FIFO entries and also the maximum of (FIFO occupancy + in-flight requests); power of 2, at least 2
RESET_PC, 64'd0, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
redirect_valid  in  1  flush the queue and restart fetch at redirect_pc
redirect_pc  in  64  new fetch address
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  64  fetch address
imem_rsp_valid  in  1  response valid; responses return in order, latency 0 or more cycles
imem_rsp_data  in  32  fetched instruction
out_valid  out  1  head entry valid to IF/ID
out_ready  in  1  IF/ID accepts head entry
out_pc  out  64  PC of head entry
out_ins  out  32  instruction of head entry
out_branch  out  1  predecode: head entry is a conditional branch (PREDECODE_EN only)

Behaviour:
- State: fetch_pc (64), rsp_pc (64), FIFO count, outstanding count, drop count. Counter widths are clog2(DEPTH+1).
- Reset (asynchronous): fetch_pc = rsp_pc = RESET_PC; count = outstanding = drop = 0; FIFO pointers = 0. While reset is asserted, imem_req_valid = 0, out_valid = 0, out_pc = 0, out_ins = 0, out_branch = 0.
- Request: imem_req_valid = !reset && !redirect_valid && (count + outstanding < DEPTH). imem_req_addr = fetch_pc.
- Request fire: req_valid & req_ready. On fire, fetch_pc += 4 and outstanding += 1.
- A request that is unaccepted when a redirect arrives is abandoned and is not counted.
- Response: when rsp_valid && outstanding > 0, outstanding -= 1.
  - If drop > 0: decrement drop and discard the data.
  - Otherwise: push {rsp_pc, rsp_data} into the FIFO and set rsp_pc += 4.
- rsp_valid with outstanding == 0 is a protocol error and is ignored.
- Credit rule (count + outstanding < DEPTH) guarantees no push into a full FIFO. The design must also never underflow.
- Output: out_valid = (count != 0) && !redirect_valid. Head fields are driven from the FIFO read pointer. Pop occurs on out_valid & out_ready.
- Latency: a response accepted in cycle N is visible on out_* in cycle N+1. There is no bypass.
- Push and pop in the same cycle leave count unchanged. Pointers wrap modulo DEPTH.
- Redirect (highest priority, one cycle):
  - FIFO is emptied (count and pointers = 0).
  - fetch_pc = rsp_pc = redirect_pc.
  - drop = outstanding − (rsp_valid && outstanding > 0 ? 1 : 0), i.e. all still-in-flight responses.
  - Any response arriving in the redirect cycle is discarded.
  - No request is issued and no pop occurs in the redirect cycle.
- Back-to-back redirects: each one recomputes drop from the current outstanding count; the last redirect_pc wins.
- redirect_pc alignment is not checked; bit[1:0] is passed through unchanged.

Optional Feature:
PREDECODE_EN
- Defined: each FIFO entry stores an is_branch bit, computed at push as (rsp_data[6:0] == 7'b1100011). This bit drives out_branch, giving the branch predictor an early hint.
- Undefined: no extra storage is built and out_branch is tied to 0.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_entry_t {pc[63:0], ins[31:0], is_branch}
  - INS_BYTES = 4
  - OPCODE_BRANCH = 7'b1100011
- Sub-module fetch_fifo is natural: a parameterised synchronous FIFO with push, pop and flush inputs, head outputs and count output. It owns the storage and pointers. The top level owns the PC, credit and drop logic.

Test Plan:
1. Reset deassert, req_ready=1, rsp 1 cycle later, out_ready=1 -> requests at 0x0, 0x4, 0x8 on consecutive cycles; out_pc 0x0, 0x4, 0x8 with matching instructions; each appears 1 cycle after its response.
2. out_ready=0, DEPTH=4 -> exactly 4 requests issued; req_valid then stays 0. Raising out_ready for one pop -> exactly one new request at 0x10.
3. 3 requests in flight, redirect_pc=0x100 -> out_valid=0 next cycle; the 3 stale responses are dropped; first out_pc = 0x100.
4. Redirect in the same cycle as an rsp_valid with outstanding=2 -> drop=1; the response is discarded; the next two responses yield one dropped response, then out_pc = redirect_pc.
5. Assert reset mid-stream with FIFO full and 0 outstanding -> outputs go to 0 immediately; after release, fetch restarts at RESET_PC.
6. PREDECODE_EN defined, responses 0x00000063 then 0x00000013 -> out_branch = 1 then 0. Undefined -> out_branch = 0 for both.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package fetch_pkg;

    localparam int         INS_BYTES     = 4;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
        logic        is_branch;
    } fetch_entry_t;

    function automatic logic is_branch_op(input logic [6:0] opcode);
        return opcode == OPCODE_BRANCH;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding fetched entries; flush empties it in one cycle.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 96,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_queue.sv
// Decoupled fetch front end: sequential requests, in-order responses, {PC, ins} FIFO.
// Optional macro PREDECODE_EN stores a per-entry conditional-branch hint driving out_branch.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_pc,
    output logic [31:0] out_ins,
    output logic        out_branch
);

    localparam int CW = $clog2(DEPTH + 1);
`ifdef PREDECODE_EN
    localparam int ENTRY_W = 97;
`else
    localparam int ENTRY_W = 96;
`endif

    logic [63:0]        fetch_pc;
    logic [63:0]        rsp_pc;
    logic [CW-1:0]      count;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      drop;
    logic [CW:0]        inflight;
    logic               req_fire;
    logic               rsp_take;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] push_data;
    logic [ENTRY_W-1:0] head_bits;
    fetch_entry_t       head;

    // Credit: buffered entries plus in-flight requests never exceed DEPTH.
    assign inflight       = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !reset && !redirect_valid && (inflight < (CW + 1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_take  = imem_rsp_valid && (outstanding != '0);
    assign push      = rsp_take && (drop == '0) && !redirect_valid;
    assign out_valid = !reset && (count != '0) && !redirect_valid;
    assign pop       = out_valid && out_ready;

`ifdef PREDECODE_EN
    assign push_data = {rsp_pc, imem_rsp_data, is_branch_op(imem_rsp_data[6:0])};
    assign head      = head_bits;
`else
    assign push_data = {rsp_pc, imem_rsp_data};
    assign head      = {head_bits, 1'b0};
`endif

    assign out_pc     = reset ? 64'd0 : head.pc;
    assign out_ins    = reset ? 32'd0 : head.ins;
    assign out_branch = reset ? 1'b0  : head.is_branch;

    // A redirect turns every response still in flight into one to be dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else if (redirect_valid) begin
            fetch_pc    <= redirect_pc;
            rsp_pc      <= redirect_pc;
            outstanding <= outstanding - CW'(rsp_take);
            drop        <= outstanding - CW'(rsp_take);
        end else begin
            if (req_fire) fetch_pc <= fetch_pc + 64'(INS_BYTES);
            if (push)     rsp_pc   <= rsp_pc + 64'(INS_BYTES);
            case ({req_fire, rsp_take})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
            if (rsp_take && (drop != '0)) drop <= drop - CW'(1);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head_bits),
        .count     (count)
    );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: in-order memory model plus output monitor.
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc;
    logic [31:0] out_ins;
    logic        out_branch;

    inst_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_ins        (out_ins),
        .out_branch     (out_branch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [63:0] pc; logic [31:0] ins; logic br; } exp_t;
    typedef struct { logic [63:0] addr; int due; } pend_t;

    exp_t        exp_q[$];
    pend_t       pend[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_fire = 0;
    logic [63:0] last_addr = 64'd0;
    logic        rsp_hold = 1'b0;

    function automatic logic [31:0] ins_of(input logic [63:0] a);
        if (a == 64'h200) return 32'h0000_0063;
        if (a == 64'h204) return 32'h0000_0013;
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic expect_entry(input logic [63:0] pc, input logic [31:0] ins, input logic br_hint);
        exp_t e;
        e.pc  = pc;
        e.ins = ins;
`ifdef PREDECODE_EN
        e.br  = br_hint;
`else
        e.br  = 1'b0;
`endif
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int n);
        int got = 0;
        int b = 0;
        step();
        imem_req_ready = 1'b1;
        while (got < n && b < 50) begin
            @(negedge clk);
            if (imem_req_valid) got++;
            b++;
        end
        step();
        imem_req_ready = 1'b0;
        chk("issue_count", 64'(got), 64'(n));
    endtask

    task automatic wait_drain(input int budget);
        int b = 0;
        while (exp_q.size() != 0 && b < budget) begin
            @(negedge clk);
            b++;
        end
        repeat (3) @(negedge clk);
        chk("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Memory model: accepts at the edge, answers one cycle later, strictly in order.
    initial forever begin
        @(negedge clk);
        if (reset) pend.delete();
        else if (imem_req_valid && imem_req_ready) begin
            pend.push_back('{addr: imem_req_addr, due: cyc + 1});
            n_fire++;
            last_addr = imem_req_addr;
        end
        @(posedge clk);
        #2;
        if (!reset && !rsp_hold && pend.size() != 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ins_of(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'd0;
        end
    end

    // Output monitor: every accepted head entry is matched against the scoreboard.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pop: got pc 0x%0h, required no output", out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", out_pc, e.pc);
                chk("pop_ins", 64'(out_ins), 64'(e.ins));
                chk("pop_branch", 64'(out_branch), 64'(e.br));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_ins", 64'(out_ins), 64'd0);
        chk("rst_out_branch", 64'(out_branch), 64'd0);

        // Streaming fetch with one-cycle memory.
        expect_entry(64'h0, 32'h0000_0013, 1'b0);
        expect_entry(64'h4, 32'h0000_0413, 1'b0);
        expect_entry(64'h8, 32'h0000_0813, 1'b0);
        step();
        reset = 1'b0;
        imem_req_ready = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t1_req0_valid", 64'(imem_req_valid), 64'd1);
        chk("t1_req0_addr", imem_req_addr, 64'h0);
        @(negedge clk);
        chk("t1_req1_addr", imem_req_addr, 64'h4);
        chk("t1_out_not_yet", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t1_req2_addr", imem_req_addr, 64'h8);
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_out_pc", out_pc, 64'h0);
        step();
        imem_req_ready = 1'b0;
        wait_drain(20);

        // Credit limit with a stalled decode stage.
        step();
        reset = 1'b1;
        out_ready = 1'b0;
        step();
        reset = 1'b0;
        n0 = n_fire;
        imem_req_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("t2_fire_count", 64'(n_fire - n0), 64'd4);
        chk("t2_req_stalled", 64'(imem_req_valid), 64'd0);
        expect_entry(64'h0,  32'h0000_0013, 1'b0);
        expect_entry(64'h4,  32'h0000_0413, 1'b0);
        expect_entry(64'h8,  32'h0000_0813, 1'b0);
        expect_entry(64'hC,  32'h0000_0C13, 1'b0);
        expect_entry(64'h10, 32'h0000_1013, 1'b0);
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("t2_refill_count", 64'(n_fire - n0), 64'd5);
        chk("t2_refill_addr", last_addr, 64'h10);
        chk("t2_req_stalled_again", 64'(imem_req_valid), 64'd0);
        step();
        imem_req_ready = 1'b0;
        out_ready = 1'b1;
        wait_drain(30);

        // Redirect with three requests in flight.
        rsp_hold = 1'b1;
        issue(3);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 64'h100;
        @(negedge clk);
        chk("t3_redir_no_req", 64'(imem_req_valid), 64'd0);
        chk("t3_redir_no_out", 64'(out_valid), 64'd0);
        step();
        redirect_valid = 1'b0;
        rsp_hold = 1'b0;
        @(negedge clk);
        chk("t3_out_empty_after", 64'(out_valid), 64'd0);
        chk("t3_restart_addr", imem_req_addr, 64'h100);
        expect_entry(64'h100, 32'h0001_0013, 1'b0);
        expect_entry(64'h104, 32'h0001_0413, 1'b0);
        issue(2);
        wait_drain(30);

        // Redirect coinciding with a response, two outstanding; predecode hint.
        rsp_hold = 1'b1;
        issue(2);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 64'h200;
        rsp_hold = 1'b0;
        @(negedge clk);
        chk("t4_redir_no_req", 64'(imem_req_valid), 64'd0);
        chk("t4_redir_no_out", 64'(out_valid), 64'd0);
        step();
        redirect_valid = 1'b0;
        expect_entry(64'h200, 32'h0000_0063, 1'b1);
        expect_entry(64'h204, 32'h0000_0013, 1'b0);
        issue(2);
        wait_drain(30);

        // Reset with the FIFO full and nothing in flight.
        step();
        out_ready = 1'b0;
        issue(4);
        repeat (4) @(negedge clk);
        chk("t5_full_valid", 64'(out_valid), 64'd1);
        chk("t5_full_no_req", 64'(imem_req_valid), 64'd0);
        chk("t5_head_pc", out_pc, 64'h208);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_req_valid", 64'(imem_req_valid), 64'd0);
        chk("t5_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t5_rst_out_pc", out_pc, 64'd0);
        chk("t5_rst_out_ins", 64'(out_ins), 64'd0);
        chk("t5_rst_out_branch", 64'(out_branch), 64'd0);
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("t5_restart_valid", 64'(imem_req_valid), 64'd1);
        chk("t5_restart_addr", imem_req_addr, 64'h0);
        repeat (3) @(negedge clk);
        chk("end_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
